melody_sequencer: RTL

//   Event-driven tune sequencer for the jump game's sound path. Game logic pulses

---
 rtl/melody_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// Event-driven tune sequencer: steps a fixed note ROM on tick boundaries and
// feeds the buzzer's 6-bit music_scale code, with priority-based preemption.
module melody_sequencer #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play_jump,
    input  logic       play_score,
    input  logic       play_over,
    input  logic       mute,
    output logic [5:0] music_scale,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NOTE_W   = 6;
    localparam int unsigned DUR_W    = 3;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned PRI_W    = 2;
    localparam int unsigned ENTRY_W  = DUR_W + NOTE_W;

    localparam logic [PRI_W-1:0] PRI_NONE  = 2'd0;
    localparam logic [PRI_W-1:0] PRI_JUMP  = 2'd1;
    localparam logic [PRI_W-1:0] PRI_SCORE = 2'd2;
    localparam logic [PRI_W-1:0] PRI_OVER  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    tick_cnt, tick_cnt_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [DUR_W-1:0]    remaining, remaining_n;
    logic [NOTE_W-1:0]   note_reg, note_n;
    logic [PRI_W-1:0]    cur_pri, cur_pri_n;
    logic                busy_n;
    logic                done_n;

    logic                tick;
    logic [PRI_W-1:0]    req_pri;
    logic [ADDR_W-1:0]   req_base;
    logic                start;
    logic [ENTRY_W-1:0]  base_entry;
    logic [ADDR_W-1:0]   next_addr;
    logic [ENTRY_W-1:0]  next_entry;

    // Note ROM: {dur[2:0], note[5:0]}; dur==0 terminates a tune.
    function automatic logic [ENTRY_W-1:0] rom_entry(input logic [ADDR_W-1:0] a);
        logic [ENTRY_W-1:0] e;
        case (a)
            4'd0:    e = {3'd1, 6'd15};
            4'd1:    e = {3'd1, 6'd19};
            4'd3:    e = {3'd1, 6'd8};
            4'd4:    e = {3'd1, 6'd10};
            4'd5:    e = {3'd1, 6'd12};
            4'd6:    e = {3'd2, 6'd15};
            4'd8:    e = {3'd2, 6'd12};
            4'd9:    e = {3'd2, 6'd11};
            4'd10:   e = {3'd2, 6'd10};
            4'd11:   e = {3'd4, 6'd8};
            default: e = '0;
        endcase
        return e;
    endfunction

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    // Request priority encoder: over > score > jump.
    always_comb begin
        req_pri  = PRI_NONE;
        req_base = 4'd0;
        if (play_over) begin
            req_pri  = PRI_OVER;
            req_base = 4'd8;
        end else if (play_score) begin
            req_pri  = PRI_SCORE;
            req_base = 4'd3;
        end else if (play_jump) begin
            req_pri  = PRI_JUMP;
            req_base = 4'd0;
        end
    end

    assign base_entry = rom_entry(req_base);
    assign next_addr  = ADDR_W'(addr + 4'd1);
    assign next_entry = rom_entry(next_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            addr      <= '0;
            remaining <= '0;
            note_reg  <= '0;
            cur_pri   <= PRI_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            note_reg  <= note_n;
            cur_pri   <= cur_pri_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        tick_cnt_n  = tick ? '0 : CNT_W'(tick_cnt + CNT_W'(1));
        addr_n      = addr;
        remaining_n = remaining;
        note_n      = note_reg;
        cur_pri_n   = cur_pri;
        busy_n      = busy;
        done_n      = 1'b0;
        start       = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_pri != PRI_NONE) start = 1'b1;
            end
            S_PLAY: begin
                if (req_pri > cur_pri) begin
                    start = 1'b1;
                end else if (tick) begin
                    if (remaining > 3'd1) begin
                        remaining_n = DUR_W'(remaining - 3'd1);
                    end else begin
                        addr_n = next_addr;
                        if (next_entry[ENTRY_W-1:NOTE_W] != 3'd0) begin
                            note_n      = next_entry[NOTE_W-1:0];
                            remaining_n = next_entry[ENTRY_W-1:NOTE_W];
                        end else begin
                            note_n      = '0;
                            remaining_n = '0;
                            cur_pri_n   = PRI_NONE;
                            busy_n      = 1'b0;
                            done_n      = 1'b1;
                            state_n     = S_END;
                        end
                    end
                end
            end
            S_END: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n   = S_IDLE;
                note_n    = '0;
                busy_n    = 1'b0;
                cur_pri_n = PRI_NONE;
            end
        endcase

        // A start (fresh or preempting) discards any coincident tick.
        if (start) begin
            state_n     = S_PLAY;
            tick_cnt_n  = '0;
            addr_n      = req_base;
            note_n      = base_entry[NOTE_W-1:0];
            remaining_n = base_entry[ENTRY_W-1:NOTE_W];
            cur_pri_n   = req_pri;
            busy_n      = 1'b1;
        end
    end

    assign music_scale = (mute || state != S_PLAY) ? 6'd0 : note_reg;

endmodule
